// File: rtl/product_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// product_accumulator : sums each group of COUNT unsigned products, valid/ready
// on both sides. Optional clamp-on-overflow via PRODUCT_ACC_SATURATE_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int COUNT  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_HOLD    = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_ovf_q, out_ovf_d;

  logic [ACC_W:0]     sum_wide;
  logic               carry;
  logic [ACC_W-1:0]   acc_next;
  logic               accept;

  assign sum_wide = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
  assign carry    = sum_wide[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
  // Once clamped, acc is all-ones, so any further non-zero add carries again
  // and the clamp persists for the rest of the group.
  assign acc_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign acc_next = sum_wide[ACC_W-1:0];
`endif

  assign in_ready  = (state_q == S_COLLECT) && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_HOLD);
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    out_sum_d = out_sum_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      S_COLLECT: begin
        if (clear) begin
          acc_d     = '0;
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
        end else if (accept) begin
          if (cnt_q == CNT_LAST) begin
            out_sum_d = acc_next;
            out_ovf_d = ovf_acc_q | carry;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
            state_d   = S_HOLD;
          end else begin
            acc_d     = acc_next;
            cnt_d     = cnt_q + 1'b1;
            ovf_acc_d = ovf_acc_q | carry;
          end
        end
      end
      S_HOLD: begin
        // clear is deliberately ignored here: a finished result is never lost.
        if (out_ready) begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_COLLECT;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      out_sum_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      out_sum_q <= out_sum_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_product_accumulator : three instances (default, ACC_W=17, COUNT=1) share
// one stimulus stream; each is compared against its own group-sum model.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_prod = '0;

  logic [NDUT-1:0] in_ready, out_valid, out_ovf;
  logic [23:0] sum0;
  logic [16:0] sum1;
  logic [23:0] sum2;

  int n_chk  = 0;
  int n_pass = 0;

  bit     mhold [NDUT];
  longint tot   [NDUT];
  int     ncnt  [NDUT];
  longint esum  [NDUT];
  bit     eovf  [NDUT];

  always #5 clk = ~clk;

  product_accumulator dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_prod(in_prod), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_sum(sum0), .out_ovf(out_ovf[0])
  );

  product_accumulator #(.ACC_W(17)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_prod(in_prod), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_sum(sum1), .out_ovf(out_ovf[1])
  );

  product_accumulator #(.COUNT(1)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_prod(in_prod), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_sum(sum2), .out_ovf(out_ovf[2])
  );

  function automatic int acc_w_of(input int k);
    return (k == 1) ? 17 : 24;
  endfunction

  function automatic int count_of(input int k);
    return (k == 2) ? 1 : 8;
  endfunction

  function automatic logic [31:0] sum_of(input int k);
    case (k)
      0:       return 32'(sum0);
      1:       return 32'(sum1);
      default: return 32'(sum2);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      mhold[k] = 1'b0; tot[k] = 0; ncnt[k] = 0; esum[k] = 0; eovf[k] = 1'b0;
    end
  endtask

  // Group result from the plain total: overflow iff the true sum exceeds the range.
  task automatic finish_group(input int k);
    longint lim = longint'(1) << acc_w_of(k);
    if (tot[k] >= lim) begin
      eovf[k] = 1'b1;
`ifdef PRODUCT_ACC_SATURATE_EN
      esum[k] = lim - 1;
`else
      esum[k] = tot[k] % lim;
`endif
    end else begin
      eovf[k] = 1'b0;
      esum[k] = tot[k];
    end
    mhold[k] = 1'b1;
    tot[k]   = 0;
    ncnt[k]  = 0;
  endtask

  // One clock: check registered outputs, drive inputs, check in_ready, advance model.
  task automatic step(input bit r, input bit c, input bit v, input bit ordy, input logic [15:0] p);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("d%0d_out_valid", k), 32'(out_valid[k]), 32'(mhold[k]));
      check($sformatf("d%0d_out_sum", k), sum_of(k), 32'(esum[k]));
      check($sformatf("d%0d_out_ovf", k), 32'(out_ovf[k]), 32'(eovf[k]));
    end
    rst = r; clear = c; in_valid = v; out_ready = ordy; in_prod = p;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("d%0d_in_ready", k), 32'(in_ready[k]), 32'(!mhold[k] && !c));
    end
    for (int k = 0; k < NDUT; k++) begin
      if (!r) begin
        mhold[k] = 1'b0; tot[k] = 0; ncnt[k] = 0; esum[k] = 0; eovf[k] = 1'b0;
      end else if (mhold[k]) begin
        if (ordy) mhold[k] = 1'b0;
      end else if (c) begin
        tot[k] = 0; ncnt[k] = 0;
      end else if (v) begin
        tot[k] += longint'(p);
        ncnt[k]++;
        if (ncnt[k] == count_of(k)) finish_group(k);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 1, 16'h0);
  endtask

  initial begin
    model_reset();
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    idle(2);

    // 8 x 255*255 back to back
    for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 16'hFE01);
    step(1, 0, 0, 1, 16'h0);
    check("fe01_sum_acc24", 32'(sum0), 32'h07F008);
    check("fe01_ovf_acc24", 32'(out_ovf[0]), 32'h0);
`ifdef PRODUCT_ACC_SATURATE_EN
    check("fe01_sum_acc17", 32'(sum1), 32'h1FFFF);
`else
    check("fe01_sum_acc17", 32'(sum1), 32'h1F008);
`endif
    check("fe01_ovf_acc17", 32'(out_ovf[1]), 32'h1);
    idle(2);

    // products 1..8, then backpressure for 5 cycles
    for (int i = 1; i <= 8; i++) step(1, 0, 1, 0, 16'(i));
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 16'h0);
    check("hold_sum_1to8", 32'(sum0), 32'd36);
    step(1, 0, 0, 1, 16'h0);
    idle(3);

    // partial group discarded by clear
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 16'd100);
    step(1, 1, 1, 1, 16'd100);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 16'd1);
    step(1, 0, 0, 1, 16'h0);
    check("clear_sum", 32'(sum0), 32'd8);
    idle(2);

    // reset mid-group
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 16'd50);
    step(0, 0, 0, 1, 16'h0);
    step(0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 1, 16'd2);
    step(1, 0, 0, 1, 16'h0);
    check("post_reset_sum", 32'(sum0), 32'd16);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          r  = ($urandom_range(0, 299) != 0);
      bit          c  = ($urandom_range(0, 19) == 0);
      bit          v  = ($urandom_range(0, 3) != 0);
      bit          o  = ($urandom_range(0, 3) != 0);
      logic [15:0] p;
      case ($urandom_range(0, 3))
        0:       p = 16'hFFFF;
        1:       p = 16'(($urandom_range(0, 255)) * ($urandom_range(0, 255)));
        2:       p = 16'($urandom_range(0, 15));
        default: p = 16'($urandom);
      endcase
      step(r, c, v, o, p);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
